// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: synchronises and debounces two push-buttons and turns
// accepted presses into single-cycle, mutually exclusive S/R pulses.
module sr_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 5
) (
    input  logic CLK,
    input  logic RST_L,
    input  logic SET_BTN,
    input  logic RST_BTN,
    output logic S,
    output logic R,
    output logic S_STABLE,
    output logic R_STABLE,
    output logic CONFLICT
);

    typedef enum logic [1:0] {
        LO,
        WAIT_HI,
        HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // channel 0 = set button, channel 1 = reset button
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       rise;
    logic [1:0]       fall;
    logic [1:0]       stable_q;
    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];

    assign raw = {RST_BTN, SET_BTN};

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= LO;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            rise[i]    = 1'b0;
            fall[i]    = 1'b0;
            unique case (state_q[i])
                LO: begin
                    if (sync2[i]) begin
                        state_d[i] = WAIT_HI;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync2[i]) begin
                        state_d[i] = LO;
                    end else if (cnt_q[i] == TERM) begin
                        state_d[i] = HI;
                        rise[i]    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HI: begin
                    if (!sync2[i]) begin
                        state_d[i] = WAIT_LO;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_LO: begin
                    if (sync2[i]) begin
                        state_d[i] = HI;
                    end else if (cnt_q[i] == TERM) begin
                        state_d[i] = LO;
                        fall[i]    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: state_d[i] = LO;
            endcase
        end
    end

    // simultaneous rises are suppressed and flagged instead
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            stable_q <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            CONFLICT <= 1'b0;
        end else begin
            stable_q <= (stable_q | rise) & ~fall;
            S        <= rise[0] & ~rise[1];
            R        <= rise[1] & ~rise[0];
            CONFLICT <= &rise;
        end
    end

    assign S_STABLE = stable_q[0];
    assign R_STABLE = stable_q[1];

endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb_sr_pulse_gen: vector tables, directed corner sequences and random
// stimulus compared against a run-length debounce model.
module tb_sr_pulse_gen;

    localparam int D = 4;

    logic CLK = 1'b0;
    logic RST_L;
    logic SET_BTN;
    logic RST_BTN;
    logic S;
    logic R;
    logic S_STABLE;
    logic R_STABLE;
    logic CONFLICT;

    int checks = 0;
    int errors = 0;
    int s_cnt;
    int r_cnt;
    int c_cnt;

    typedef struct packed {
        logic       set;
        logic       rst;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [18];

    // model: 2-edge input delay, then a level flips once it has
    // differed from the stable level for D+1 consecutive samples
    logic [1:0] hist [$];
    int         run  [2];
    bit         m_stable [2];
    bit         m_s;
    bit         m_r;
    bit         m_c;

    sr_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
        .CLK      (CLK),
        .RST_L    (RST_L),
        .SET_BTN  (SET_BTN),
        .RST_BTN  (RST_BTN),
        .S        (S),
        .R        (R),
        .S_STABLE (S_STABLE),
        .R_STABLE (R_STABLE),
        .CONFLICT (CONFLICT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4:0] outs();
        return {S, R, S_STABLE, R_STABLE, CONFLICT};
    endfunction

    function automatic logic [4:0] mouts();
        return {m_s, m_r, m_stable[0], m_stable[1], m_c};
    endfunction

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            run[i]      = 0;
            m_stable[i] = 1'b0;
        end
        m_s = 1'b0;
        m_r = 1'b0;
        m_c = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [1:0] seen;
        bit         rose [2];
        if (!RST_L) begin
            model_reset();
            return;
        end
        hist.push_back({RST_BTN, SET_BTN});
        seen = 2'b00;
        if (hist.size() > 2) seen = hist.pop_front();
        for (int i = 0; i < 2; i++) begin
            rose[i] = 1'b0;
            if (seen[i] != m_stable[i]) begin
                run[i]++;
                if (run[i] == D + 1) begin
                    m_stable[i] = seen[i];
                    run[i]      = 0;
                    rose[i]     = seen[i];
                end
            end else begin
                run[i] = 0;
            end
        end
        m_s = rose[0] && !rose[1];
        m_r = rose[1] && !rose[0];
        m_c = rose[0] && rose[1];
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("model", outs(), mouts());
        chk("mutex", S & R, 1'b0);
        s_cnt += int'(S);
        r_cnt += int'(R);
        c_cnt += int'(CONFLICT);
    endtask

    task automatic idle(int n);
        SET_BTN = 1'b0;
        RST_BTN = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clr_cnt();
        s_cnt = 0;
        r_cnt = 0;
        c_cnt = 0;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            vecs[i] = '{1'b1, 1'b0,
                        (i == 6) ? 5'b10100 :
                        (i > 6)  ? 5'b00100 : 5'b00000};
            vecs[9 + i] = '{1'b1, 1'b1,
                            (i == 6) ? 5'b00111 :
                            (i > 6)  ? 5'b00110 : 5'b00000};
        end
        clr_cnt();
        SET_BTN = 1'b0;
        RST_BTN = 1'b0;
        RST_L   = 1'b1;

        // asynchronous reset before any clock edge
        #1 RST_L = 1'b0;
        model_reset();
        #1 chk("reset_async", outs(), 5'b00000);
        SET_BTN = 1'b1;
        RST_BTN = 1'b1;
        tick();
        SET_BTN = 1'b0;
        tick();
        RST_BTN = 1'b0;
        SET_BTN = 1'b1;
        tick();
        chk("reset_held", outs(), 5'b00000);
        SET_BTN = 1'b0;
        RST_L   = 1'b1;
        idle(6);
        chk("reset_release", outs(), 5'b00000);

        // clean set press
        clr_cnt();
        for (int i = 0; i < 9; i++) begin
            SET_BTN = vecs[i].set;
            RST_BTN = vecs[i].rst;
            tick();
            chk("clean_press", outs(), vecs[i].exp);
        end
        repeat (11) tick();
        chk("clean_s_count", s_cnt, 1);
        chk("clean_r_count", r_cnt + c_cnt, 0);

        // async reset while S_STABLE is high
        #2 RST_L = 1'b0;
        model_reset();
        #1 chk("reset_mid_stable", outs(), 5'b00000);
        RST_BTN = 1'b1;
        tick();
        SET_BTN = 1'b0;
        RST_BTN = 1'b0;
        RST_L   = 1'b1;
        idle(8);

        // bounce rejection on reset button
        clr_cnt();
        begin
            logic [11:0] pat;
            pat = 12'b111011100000;
            for (int i = 11; i >= 0; i--) begin
                RST_BTN = pat[i];
                tick();
                chk("bounce_r_stable", R_STABLE, 1'b0);
            end
        end
        chk("bounce_no_pulse", r_cnt, 0);
        RST_BTN = 1'b1;
        repeat (12) tick();
        chk("bounce_one_pulse", r_cnt, 1);
        chk("bounce_r_stable_hi", R_STABLE, 1'b1);
        idle(10);
        chk("bounce_released", R_STABLE, 1'b0);

        // release and re-press
        clr_cnt();
        SET_BTN = 1'b1;
        repeat (10) tick();
        SET_BTN = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) chk("release_hold", S_STABLE, 1'b1);
            if (k == 7) chk("release_fall", S_STABLE, 1'b0);
        end
        chk("release_no_pulse", s_cnt, 1);
        SET_BTN = 1'b1;
        repeat (10) tick();
        chk("repress_pulses", s_cnt, 2);
        idle(12);

        // simultaneous press
        clr_cnt();
        for (int i = 9; i < 18; i++) begin
            SET_BTN = vecs[i].set;
            RST_BTN = vecs[i].rst;
            tick();
            chk("simul_press", outs(), vecs[i].exp);
        end
        repeat (3) tick();
        chk("simul_sr", s_cnt + r_cnt, 0);
        chk("simul_conflict", c_cnt, 1);
        idle(12);

        // reset mid-debounce
        clr_cnt();
        SET_BTN = 1'b1;
        repeat (4) tick();
        RST_L = 1'b0;
        model_reset();
        tick();
        tick();
        RST_L = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rst_debounce_s", S, (k == 7) ? 1'b1 : 1'b0);
        end
        repeat (6) tick();
        chk("rst_debounce_count", s_cnt, 1);
        idle(12);

        // random segments with occasional asynchronous resets
        for (int seg = 0; seg < 600; seg++) begin
            SET_BTN = 1'($urandom_range(0, 1));
            RST_BTN = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 9)) tick();
            if ($urandom_range(0, 59) == 0) begin
                #2 RST_L = 1'b0;
                model_reset();
                #1 chk("rand_reset", outs(), 5'b00000);
                tick();
                RST_L = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
